serial_nibble_comparator: RTL

//   Sequential magnitude comparator for words of NIBBLES*4 bits. Steps MSB-first, one nibble per clock.

---
 rtl/serial_nibble_comparator_pkg.sv | 22 ++
 rtl/four_bit_comparator.sv | 14 +
 rtl/serial_nibble_comparator.sv | 98 +++++++++
 3 files changed

// File: rtl/serial_nibble_comparator_pkg.sv
// Shared definitions for the serial nibble comparator: nibble width,
// FSM state encoding and one-hot result bit positions.
package serial_nibble_comparator_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPARE = 2'b01,
    DONE    = 2'b10
  } state_t;

  localparam int RES_EQ = 0;
  localparam int RES_GT = 1;
  localparam int RES_LT = 2;

  // A single-nibble word still needs a 1-bit index register.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/four_bit_comparator.sv
// Combinational unsigned magnitude comparator for one nibble pair.
module four_bit_comparator (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       eq,
  output logic       gt,
  output logic       lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/serial_nibble_comparator.sv
// Sequential MSB-first magnitude comparator: one nibble per clock, stopping
// at the first unequal nibble, with a start/busy/done handshake.
module serial_nibble_comparator
  import serial_nibble_comparator_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NIBBLES*4-1:0]    a_word,
  input  logic [NIBBLES*4-1:0]    b_word,
  output logic                    busy,
  output logic                    done,
  output logic                    eq,
  output logic                    gt,
  output logic                    lt
);

  localparam int W     = NIBBLES * NIBBLE_W;
  localparam int IDX_W = idx_width(NIBBLES);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [W-1:0]       a_reg;
  logic [W-1:0]       b_reg;
  logic [2:0]         result;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic               nib_eq;
  logic               nib_gt;
  logic               nib_lt;

  assign nib_a = a_reg[idx*NIBBLE_W +: NIBBLE_W];
  assign nib_b = b_reg[idx*NIBBLE_W +: NIBBLE_W];

  four_bit_comparator u_nibble_cmp (
    .a  (nib_a),
    .b  (nib_b),
    .eq (nib_eq),
    .gt (nib_gt),
    .lt (nib_lt)
  );

  // Result register is cleared on accept, so only the exit edge sets one bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg  <= a_word;
            b_reg  <= b_word;
            idx    <= IDX_W'(NIBBLES - 1);
            result <= '0;
            busy   <= 1'b1;
            state  <= COMPARE;
          end else begin
            state <= IDLE;
          end
        end
        COMPARE: begin
          if (nib_gt || nib_lt) begin
            result[RES_GT] <= nib_gt;
            result[RES_LT] <= nib_lt;
            busy           <= 1'b0;
            done           <= 1'b1;
            state          <= DONE;
          end else if (idx == '0) begin
            result[RES_EQ] <= nib_eq;
            busy           <= 1'b0;
            done           <= 1'b1;
            state          <= DONE;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign eq = result[RES_EQ];
  assign gt = result[RES_GT];
  assign lt = result[RES_LT];

endmodule
